alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 183 ++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a one-entry skid buffer and valid/ready handshakes.
// Define ALU_EXEC_OVF_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    localparam logic [2:0] OP_NOTHING = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b010;
    localparam logic [2:0] OP_AND     = 3'b011;
    localparam logic [2:0] OP_OR      = 3'b100;
    localparam logic [2:0] OP_SLT     = 3'b101;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;

    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic             out_zero_q, out_zero_d;
    logic [WIDTH-1:0] skid_res_q, skid_res_d;
    logic             skid_zero_q, skid_zero_d;

    logic in_xfer;
    logic out_xfer;
    logic load_out_new;
    logic load_skid;
    logic move_skid;

    // ALU proper
    always_comb begin
        alu_res = '0;
        case (op)
            OP_NOTHING: alu_res = '0;
            OP_ADD:     alu_res = a + b;
            OP_SUB:     alu_res = a - b;
            OP_AND:     alu_res = a & b;
            OP_OR:      alu_res = a | b;
            OP_SLT:     alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:    alu_res = '0;
        endcase
    end

    assign alu_zero = (alu_res == '0);

    // Handshake: in_ready is a pure function of state so it never loops back from out_ready.
    assign in_ready  = (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        load_out_new = 1'b0;
        load_skid    = 1'b0;
        move_skid    = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    load_out_new = 1'b1;
                    state_d      = S_ONE;
                end
            end
            S_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_out_new = 1'b1;
                    state_d      = S_ONE;
                end else if (out_xfer) begin
                    state_d = S_EMPTY;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_d   = S_TWO;
                end
            end
            S_TWO: begin
                if (out_xfer) begin
                    move_skid = 1'b1;
                    state_d   = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        out_res_d   = out_res_q;
        out_zero_d  = out_zero_q;
        skid_res_d  = skid_res_q;
        skid_zero_d = skid_zero_q;
        if (load_out_new) begin
            out_res_d  = alu_res;
            out_zero_d = alu_zero;
        end else if (move_skid) begin
            out_res_d  = skid_res_q;
            out_zero_d = skid_zero_q;
        end
        if (load_skid) begin
            skid_res_d  = alu_res;
            skid_zero_d = alu_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_res_q   <= '0;
            out_zero_q  <= 1'b0;
            skid_res_q  <= '0;
            skid_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_res_q   <= out_res_d;
            out_zero_q  <= out_zero_d;
            skid_res_q  <= skid_res_d;
            skid_zero_q <= skid_zero_d;
        end
    end

    assign result = out_res_q;
    assign zero   = out_zero_q;

`ifdef ALU_EXEC_OVF_EN
    logic alu_ovf;
    logic out_ovf_q, out_ovf_d;
    logic skid_ovf_q, skid_ovf_d;

    always_comb begin
        alu_ovf = 1'b0;
        case (op)
            OP_ADD:  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            default: alu_ovf = 1'b0;
        endcase
    end

    always_comb begin
        out_ovf_d  = out_ovf_q;
        skid_ovf_d = skid_ovf_q;
        if (load_out_new) begin
            out_ovf_d = alu_ovf;
        end else if (move_skid) begin
            out_ovf_d = skid_ovf_q;
        end
        if (load_skid) begin
            skid_ovf_d = alu_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ovf_q  <= 1'b0;
            skid_ovf_q <= 1'b0;
        end else begin
            out_ovf_q  <= out_ovf_d;
            skid_ovf_q <= skid_ovf_d;
        end
    end

    assign ovf = out_ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table in streaming mode plus backpressure and reset sequences.
module tb_alu_exec_stage;

    localparam int W = 32;
`ifdef ALU_EXEC_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_exec_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         o;   // overflow expected when the flag is built
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'b001, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1]  = '{3'b010, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[2]  = '{3'b010, 32'd7,          32'd7,          32'd0,          1'b1, 1'b0};
        vecs[3]  = '{3'b011, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0};
        vecs[4]  = '{3'b100, 32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF,  1'b0, 1'b0};
        vecs[5]  = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[6]  = '{3'b101, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[7]  = '{3'b000, 32'd3,          32'd4,          32'd0,          1'b1, 1'b0};
        vecs[8]  = '{3'b110, 32'd3,          32'd3,          32'd0,          1'b1, 1'b0};
        vecs[9]  = '{3'b111, 32'h7FFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[10] = '{3'b001, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
        vecs[11] = '{3'b010, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[12] = '{3'b001, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[13] = '{3'b001, 32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'b000;
        a         = '0;
        b         = '0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_result",    result,             32'd0);
        check("rst_zero",      {31'd0, zero},      32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming: one vector per cycle, exercising simultaneous in/out transfer in ONE.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            op       = vecs[i].op;
            a        = vecs[i].a;
            b        = vecs[i].b;
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].z});
            check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].o & OVF_EN});
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("drain_empty", {31'd0, out_valid}, 32'd0);

        // Backpressure: ADD(1,1) then SUB(9,4) with out_ready low.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'b001; a = 32'd1; b = 32'd1;
        tick();
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        check("bp_first_res",   result,             32'd2);
        check("bp_ready_one",   {31'd0, in_ready},  32'd1);
        op = 3'b010; a = 32'd9; b = 32'd4;
        tick();
        check("bp_ready_two",   {31'd0, in_ready},  32'd0);
        check("bp_hold_res",    result,             32'd2);
        op = 3'b001; a = 32'd100; b = 32'd100;  // must be ignored while full
        tick();
        check("bp_hold_res2",   result,             32'd2);
        check("bp_hold_zero",   {31'd0, zero},      32'd0);
        check("bp_ready_two2",  {31'd0, in_ready},  32'd0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("bp_skid_res",    result,             32'd5);
        check("bp_skid_valid",  {31'd0, out_valid}, 32'd1);
        check("bp_ready_back",  {31'd0, in_ready},  32'd1);
        tick();
        check("bp_drained",     {31'd0, out_valid}, 32'd0);
        tick();
        check("bp_no_dup",      {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while holding two entries.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = 3'b001; a = 32'd20; b = 32'd22;
        tick();
        op = 3'b100; a = 32'h0F; b = 32'hF0;
        tick();
        in_valid = 1'b0;
        check("two_before_rst", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        check("arst_result",    result,             32'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_rst_idle%0d", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("post_rst_ready%0d", i), {31'd0, in_ready}, 32'd1);
        end

        // Fresh transaction after reset.
        in_valid = 1'b1;
        op = 3'b001; a = 32'd5; b = 32'd7;
        tick();
        in_valid = 1'b0;
        check("final_valid", {31'd0, out_valid}, 32'd1);
        check("final_res",   result,             32'd12);
        check("final_zero",  {31'd0, zero},      32'd0);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
